// File: rtl/btn_debounce.sv
// Multi-channel push-button conditioner: 2-FF sync, polarity normalise, stability counter.
// Optional sticky press-event flags and IRQ output are built when DEBOUNCE_IRQ_EN is defined.
module btn_debounce #(
  parameter int unsigned WIDTH           = 6,
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter int unsigned ACTIVE_LOW      = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_btn,
  output logic [WIDTH-1:0] o_state,
  output logic [WIDTH-1:0] o_press_stb,
  output logic [WIDTH-1:0] o_release_stb
`ifdef DEBOUNCE_IRQ_EN
  ,
  input  logic [WIDTH-1:0] i_event_clr,
  output logic [WIDTH-1:0] o_event,
  output logic             o_irq
`endif
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic REL_LVL = (ACTIVE_LOW != 0);

  logic [WIDTH-1:0] r_ff1;
  logic [WIDTH-1:0] r_ff2;
  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] r_press_stb;
  logic [WIDTH-1:0] r_release_stb;
  logic [CNT_W-1:0] r_cnt [WIDTH];

  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] w_state_d;
  logic [WIDTH-1:0] w_press_d;
  logic [WIDTH-1:0] w_release_d;
  logic [CNT_W-1:0] w_cnt_d [WIDTH];

  // Sync flops reset to the released level so a held button still qualifies after reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ff1 <= {WIDTH{REL_LVL}};
      r_ff2 <= {WIDTH{REL_LVL}};
    end else begin
      r_ff1 <= i_btn;
      r_ff2 <= r_ff1;
    end
  end

  assign w_s = r_ff2 ^ {WIDTH{REL_LVL}};

  always_comb begin
    w_state_d   = r_state;
    w_press_d   = '0;
    w_release_d = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      w_cnt_d[i] = r_cnt[i];
      if (w_s[i] == r_state[i]) begin
        w_cnt_d[i] = '0;
      end else if (r_cnt[i] == CNT_LAST) begin
        w_state_d[i]   = w_s[i];
        w_cnt_d[i]     = '0;
        w_press_d[i]   = w_s[i];
        w_release_d[i] = ~w_s[i];
      end else begin
        w_cnt_d[i] = r_cnt[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= '0;
      r_press_stb   <= '0;
      r_release_stb <= '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_state       <= w_state_d;
      r_press_stb   <= w_press_d;
      r_release_stb <= w_release_d;
      for (int i = 0; i < int'(WIDTH); i++) begin
        r_cnt[i] <= w_cnt_d[i];
      end
    end
  end

  assign o_state       = r_state;
  assign o_press_stb   = r_press_stb;
  assign o_release_stb = r_release_stb;

`ifdef DEBOUNCE_IRQ_EN
  logic [WIDTH-1:0] r_event;

  // A press strobe overrides a simultaneous clear.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_event <= '0;
    end else begin
      r_event <= (r_event & ~i_event_clr) | r_press_stb;
    end
  end

  assign o_event = r_event;
  assign o_irq   = |r_event;
`endif

endmodule
